// File: rtl/vram_xfer_pkg.sv
// Shared types and default sizing for the VRAM transfer controller.
// Optional stall timeout is enabled by defining VRAM_XFER_TIMEOUT_EN.
package vram_xfer_pkg;

  localparam int ADDR_W_DEF  = 25;
  localparam int DATA_W_DEF  = 16;
  localparam int LEN_W_DEF   = 8;
  localparam int SETTLE_DEF  = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [3:0] {
    IDLE,
    W_LOAD,
    W_SETTLE,
    W_DATA,
    W_GAP,
    R_LOAD,
    R_WAIT,
    R_REQ,
    R_CAP
  } state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vram_xfer_ctrl_if.sv
// Host and SDRAM FIFO-bridge signals of the VRAM transfer controller.
// master = controller side, slave = host/bridge side.
interface vram_xfer_ctrl_if #(
  parameter int ADDR_W = vram_xfer_pkg::ADDR_W_DEF,
  parameter int DATA_W = vram_xfer_pkg::DATA_W_DEF,
  parameter int LEN_W  = vram_xfer_pkg::LEN_W_DEF
);

  logic              vs;
  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [LEN_W-1:0]  wr_cmd_len;
  logic [DATA_W-1:0] wr_src_data;
  logic              wr_src_pop;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic [DATA_W-1:0] rd_word;
  logic              rd_word_valid;
  logic              busy;
  logic              err;

  logic              wr_full;
  logic              rd_empty;
  logic [DATA_W-1:0] readdata;
  logic              write_req;
  logic              write_ld;
  logic [ADDR_W-1:0] writeaddr;
  logic [DATA_W-1:0] writedata;
  logic              read_req;
  logic              read_ld;
  logic [ADDR_W-1:0] readaddr;

  modport master (
    input  vs, wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    input  wr_src_data, rd_start, rd_addr, rd_len,
    input  wr_full, rd_empty, readdata,
    output wr_cmd_ready, wr_src_pop, rd_word, rd_word_valid,
    output busy, err, write_req, write_ld, writeaddr,
    output writedata, read_req, read_ld, readaddr
  );

  modport slave (
    output vs, wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
    output wr_src_data, rd_start, rd_addr, rd_len,
    output wr_full, rd_empty, readdata,
    input  wr_cmd_ready, wr_src_pop, rd_word, rd_word_valid,
    input  busy, err, write_req, write_ld, writeaddr,
    input  writedata, read_req, read_ld, readaddr
  );

endinterface

// File: rtl/vram_xfer_timer.sv
// Loadable down-counter shared by the settle delay and the stall timeout.
// Holds at zero; zero_o flags expiry.
module vram_xfer_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vram_xfer_ctrl.sv
// Frame-synced write / on-demand read engine for an SDRAM FIFO bridge.
// Define VRAM_XFER_TIMEOUT_EN to compile in the sticky stall timeout (err).
module vram_xfer_ctrl #(
  parameter int ADDR_W  = vram_xfer_pkg::ADDR_W_DEF,
  parameter int DATA_W  = vram_xfer_pkg::DATA_W_DEF,
  parameter int LEN_W   = vram_xfer_pkg::LEN_W_DEF,
  parameter int SETTLE  = vram_xfer_pkg::SETTLE_DEF,
  parameter int TIMEOUT = vram_xfer_pkg::TIMEOUT_DEF
) (
  input logic              clk,
  input logic              reset,
  vram_xfer_ctrl_if.master bus
);

  import vram_xfer_pkg::*;

  localparam int TW = $clog2(imax(SETTLE, TIMEOUT) + 1);
  localparam logic [TW-1:0] SET_V = TW'(SETTLE - 1);
  localparam logic [TW-1:0] TO_V  = TW'(TIMEOUT - 1);

  state_e            state_q;
  logic              vs_q;
  logic              wpend_q, rpend_q;
  logic [ADDR_W-1:0] waddr_q, praddr_q;
  logic [LEN_W-1:0]  wlen_q, prlen_q, rlen_q;
  logic [LEN_W-1:0]  wcnt_q, rcnt_q;
  logic              write_req_q, write_ld_q, pop_q;
  logic              read_req_q, read_ld_q;
  logic [ADDR_W-1:0] writeaddr_q, readaddr_q;
  logic [DATA_W-1:0] writedata_q, rd_word_q;
  logic              rd_valid_q, busy_q;
`ifdef VRAM_XFER_TIMEOUT_EN
  logic              err_q;
`endif

  logic              vs_rise, stall;
  logic              tmr_ld, tmr_zero;
  logic [TW-1:0]     tmr_val;

  assign vs_rise = bus.vs & ~vs_q;
  assign stall   = (state_q == W_DATA && !write_req_q)
                || (state_q == R_WAIT);

  // Stall states count down; every other state keeps the timeout primed.
  always_comb begin
    tmr_ld  = 1'b1;
    tmr_val = TO_V;
    unique case (1'b1)
      state_q == W_LOAD:   tmr_val = SET_V;
      state_q == W_SETTLE: tmr_ld  = tmr_zero;
      stall:               tmr_ld  = 1'b0;
      default: ;
    endcase
  end

  vram_xfer_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (reset),
    .load_i (tmr_ld),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      wpend_q     <= 1'b0;
      rpend_q     <= 1'b0;
      waddr_q     <= '0;
      praddr_q    <= '0;
      wlen_q      <= '0;
      prlen_q     <= '0;
      rlen_q      <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      write_req_q <= 1'b0;
      write_ld_q  <= 1'b0;
      pop_q       <= 1'b0;
      read_req_q  <= 1'b0;
      read_ld_q   <= 1'b0;
      writeaddr_q <= '0;
      readaddr_q  <= '0;
      writedata_q <= '0;
      rd_word_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef VRAM_XFER_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      vs_q        <= bus.vs;
      write_req_q <= 1'b0;
      write_ld_q  <= 1'b0;
      pop_q       <= 1'b0;
      read_req_q  <= 1'b0;
      read_ld_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      // A zero-length job completes at acceptance.
      if (bus.wr_cmd_valid && !wpend_q) begin
        waddr_q <= bus.wr_cmd_addr;
        wlen_q  <= bus.wr_cmd_len;
        wpend_q <= (bus.wr_cmd_len != '0);
      end
      unique case (state_q)
        IDLE: begin
          if (vs_rise && wpend_q) begin
            state_q     <= W_LOAD;
            write_ld_q  <= 1'b1;
            writeaddr_q <= waddr_q;
            wcnt_q      <= '0;
            busy_q      <= 1'b1;
          end else if (rpend_q) begin
            state_q    <= R_LOAD;
            read_ld_q  <= 1'b1;
            readaddr_q <= praddr_q;
            rlen_q     <= prlen_q;
            rcnt_q     <= '0;
            rpend_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        W_LOAD: state_q <= W_SETTLE;
        W_SETTLE: begin
          if (tmr_zero) begin
            state_q <= W_DATA;
            if (!bus.wr_full) begin
              write_req_q <= 1'b1;
              pop_q       <= 1'b1;
              writedata_q <= bus.wr_src_data;
              wcnt_q      <= wcnt_q + 1'b1;
            end
          end
        end
        W_DATA: begin
          if (write_req_q) begin
            state_q <= W_GAP;
          end else if (!bus.wr_full) begin
            write_req_q <= 1'b1;
            pop_q       <= 1'b1;
            writedata_q <= bus.wr_src_data;
            wcnt_q      <= wcnt_q + 1'b1;
          end
`ifdef VRAM_XFER_TIMEOUT_EN
          else if (tmr_zero) begin
            err_q   <= 1'b1;
            wpend_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`endif
        end
        W_GAP: begin
          if (wcnt_q == wlen_q) begin
            state_q <= IDLE;
            wpend_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= W_DATA;
            if (!bus.wr_full) begin
              write_req_q <= 1'b1;
              pop_q       <= 1'b1;
              writedata_q <= bus.wr_src_data;
              wcnt_q      <= wcnt_q + 1'b1;
            end
          end
        end
        R_LOAD: state_q <= R_WAIT;
        R_WAIT: begin
          if (!bus.rd_empty) begin
            state_q    <= R_REQ;
            read_req_q <= 1'b1;
            rcnt_q     <= rcnt_q + 1'b1;
          end
`ifdef VRAM_XFER_TIMEOUT_EN
          else if (tmr_zero) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`endif
        end
        R_REQ: state_q <= R_CAP;
        R_CAP: begin
          rd_word_q  <= bus.readdata;
          rd_valid_q <= 1'b1;
          if (rcnt_q == rlen_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= R_WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A new request replaces any read still waiting to start.
      if (bus.rd_start) begin
        praddr_q <= bus.rd_addr;
        prlen_q  <= bus.rd_len;
        rpend_q  <= (bus.rd_len != '0);
      end
    end
  end

  assign bus.wr_cmd_ready  = !wpend_q;
  assign bus.write_req     = write_req_q;
  assign bus.write_ld      = write_ld_q;
  assign bus.writeaddr     = writeaddr_q;
  assign bus.writedata     = writedata_q;
  assign bus.wr_src_pop    = pop_q;
  assign bus.read_req      = read_req_q;
  assign bus.read_ld       = read_ld_q;
  assign bus.readaddr      = readaddr_q;
  assign bus.rd_word       = rd_word_q;
  assign bus.rd_word_valid = rd_valid_q;
  assign bus.busy          = busy_q;
`ifdef VRAM_XFER_TIMEOUT_EN
  assign bus.err           = err_q;
`else
  assign bus.err           = 1'b0;
`endif

endmodule
